// File: rtl/eig_pkg.sv
// Shared fixed-point types, defaults, saturation helper and FSM state encoding
// for the eigen-decomposition reconstruction block.
package eig_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int FRAC_W_DEF = 16;
    localparam int SAT_W      = 128;

    typedef logic signed [DATA_W_DEF-1:0] fx_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCALE,
        S_ACCUM,
        S_DONE
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word (w <= 64).
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] x,
                                                      input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        hi = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
        if (x > hi) return hi;
        if (x < ~hi) return ~hi;
        return x;
    endfunction

endpackage

// File: rtl/fx_mul.sv
// Signed fixed-point multiply: full-width product, arithmetic shift by FRAC_W
// (floor), saturated back to DATA_W.
module fx_mul
    import eig_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [DATA_W-1:0] o_p
);

    localparam int          PW   = 2 * DATA_W;
    localparam int unsigned DW_U = DATA_W;

    logic signed [PW-1:0] w_full;
    logic signed [PW-1:0] w_shift;

    assign w_full  = PW'(i_a) * PW'(i_b);
    assign w_shift = w_full >>> FRAC_W;
    assign o_p     = DATA_W'(sat(SAT_W'(w_shift), DW_U));

endmodule

// File: rtl/eigen_reconstruct.sv
// Rebuilds sum(k<K) lambda_k * v_k * v_k^T with one shared fixed-point
// multiplier: SIZE_N cycles of scaling then SIZE_N^2 MAC cycles per eigenpair.
module eigen_reconstruct
    import eig_pkg::*;
#(
    parameter int SIZE_N = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [$clog2(SIZE_N+1)-1:0]                  num_comp,
    input  logic [SIZE_N-1:0][DATA_W-1:0]                eigenvalues,
    input  logic [SIZE_N-1:0][SIZE_N-1:0][DATA_W-1:0]    eigenvector_mat,
    output logic [SIZE_N-1:0][SIZE_N-1:0][DATA_W-1:0]    mat_out,
    output logic                                         busy,
    output logic                                         f
);

    localparam int              CW   = $clog2(SIZE_N + 1);
    localparam int              IW   = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam int unsigned     DW_U = DATA_W;
    localparam logic [IW-1:0]   LAST = IW'(SIZE_N - 1);

    state_t                                     r_state;
    logic [SIZE_N-1:0][DATA_W-1:0]              r_lam;
    logic [SIZE_N-1:0][SIZE_N-1:0][DATA_W-1:0]  r_vec;
    logic [SIZE_N-1:0][DATA_W-1:0]              r_s;
    logic [SIZE_N-1:0][SIZE_N-1:0][DATA_W-1:0]  r_acc;
    logic [IW-1:0]                              r_k;
    logic [IW-1:0]                              r_klast;
    logic [IW-1:0]                              r_i;
    logic [IW-1:0]                              r_j;

    logic [IW-1:0]              w_klast;
    logic signed [DATA_W-1:0]   w_mul_a;
    logic signed [DATA_W-1:0]   w_mul_b;
    logic signed [DATA_W-1:0]   w_prod;
    logic signed [DATA_W-1:0]   w_sum;

    // Out-of-range or zero component counts fall back to all SIZE_N pairs.
    always_comb begin
        w_klast = LAST;
        if (num_comp != '0 && num_comp <= CW'(SIZE_N))
            w_klast = IW'(num_comp - CW'(1));
    end

    assign w_mul_a = (r_state == S_ACCUM) ? r_s[r_i]          : r_lam[r_k];
    assign w_mul_b = (r_state == S_ACCUM) ? r_vec[r_k][r_j]   : r_vec[r_k][r_i];

    fx_mul #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_fx_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    assign w_sum = DATA_W'(sat(SAT_W'(signed'(r_acc[r_i][r_j])) + SAT_W'(w_prod), DW_U));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lam   <= '0;
            r_vec   <= '0;
            r_s     <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_klast <= '0;
            r_i     <= '0;
            r_j     <= '0;
            mat_out <= '0;
            busy    <= 1'b0;
            f       <= 1'b0;
        end else begin
            f <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        busy    <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_lam   <= eigenvalues;
                    r_vec   <= eigenvector_mat;
                    r_klast <= w_klast;
                    r_acc   <= '0;
                    r_k     <= '0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_state <= S_SCALE;
                end
                S_SCALE: begin
                    r_s[r_i] <= w_prod;
                    if (r_i == LAST) begin
                        r_i     <= '0;
                        r_state <= S_ACCUM;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                S_ACCUM: begin
                    r_acc[r_i][r_j] <= w_sum;
                    if (r_j != LAST) begin
                        r_j <= r_j + 1'b1;
                    end else begin
                        r_j <= '0;
                        if (r_i != LAST) begin
                            r_i <= r_i + 1'b1;
                        end else begin
                            r_i <= '0;
                            if (r_k == r_klast) begin
                                r_state <= S_DONE;
                            end else begin
                                r_k     <= r_k + 1'b1;
                                r_state <= S_SCALE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    mat_out <= r_acc;
                    f       <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eigen_reconstruct.sv
// Directed self-checking bench for eigen_reconstruct: latency, result values,
// saturation, ignored restart, clamped K and asynchronous reset mid-run.
module tb_eigen_reconstruct;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam logic [DW-1:0] ONE = 32'h0001_0000;

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [3:0]           num_comp;
    logic [N-1:0][DW-1:0] eigenvalues;
    mat_t                 eigenvector_mat;
    mat_t                 mat_out;
    logic                 busy;
    logic                 f;

    int checks = 0;
    int errors = 0;
    int lat;
    mat_t exp_m;
    mat_t ident;

    eigen_reconstruct #(
        .SIZE_N (N),
        .DATA_W (DW),
        .FRAC_W (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_comp        (num_comp),
        .eigenvalues     (eigenvalues),
        .eigenvector_mat (eigenvector_mat),
        .mat_out         (mat_out),
        .busy            (busy),
        .f               (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_mat(input string tag, input mat_t exp);
        checks++;
        assert (mat_out === exp)
        else begin
            errors++;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (mat_out[i][j] !== exp[i][j]) begin
                        $error("FAIL %s: mat_out[%0d][%0d] observed %h expected %h",
                               tag, i, j, mat_out[i][j], exp[i][j]);
                        i = N;
                        j = N;
                    end
        end
    endtask

    task automatic clear_inputs();
        eigenvalues     = '0;
        eigenvector_mat = '0;
    endtask

    // Pulse start, count rising edges until f; optionally re-pulse start and
    // scramble the inputs at edge poke_at while the run is in progress.
    task automatic run(input string tag, input int poke_at, output int n_edges);
        n_edges = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, "_busy"}, 64'(busy), 64'd1);
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk);
            #1;
            if (n == poke_at) begin
                start           = 1'b1;
                num_comp        = 4'd8;
                eigenvalues     = {N{32'h0005_0000}};
                eigenvector_mat = ident;
            end else if (n == poke_at + 1) begin
                start = 1'b0;
            end
            if (f) begin
                n_edges = n;
                break;
            end
        end
        check_val({tag, "_busy_at_f"}, 64'(busy), 64'd0);
    endtask

    initial begin
        ident = '0;
        for (int i = 0; i < N; i++) ident[i][i] = ONE;

        rst      = 1'b1;
        start    = 1'b0;
        num_comp = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_f", 64'(f), 64'd0);
        check_mat("reset_mat", '0);
        @(negedge clk);
        rst = 1'b0;

        // lambda_0 = 3.0, v_0 = e_0, K = 1
        clear_inputs();
        eigenvalues[0]        = 32'h0003_0000;
        eigenvector_mat[0][0] = ONE;
        num_comp              = 4'd1;
        run("single", 0, lat);
        check_val("single_lat", 64'(lat), 64'd74);
        exp_m = '0;
        exp_m[0][0] = 32'h0003_0000;
        check_mat("single_mat", exp_m);
        @(posedge clk);
        #1;
        check_val("single_f_pulse", 64'(f), 64'd0);

        // identity, K = 8
        eigenvalues     = {N{ONE}};
        eigenvector_mat = ident;
        num_comp        = 4'd8;
        run("ident", 0, lat);
        check_val("ident_lat", 64'(lat), 64'd578);
        check_mat("ident_mat", ident);

        // two huge eigenvalues on the same direction saturate
        clear_inputs();
        eigenvalues[0]        = 32'h7FFF_0000;
        eigenvalues[1]        = 32'h7FFF_0000;
        eigenvector_mat[0][0] = ONE;
        eigenvector_mat[1][0] = ONE;
        num_comp              = 4'd2;
        run("sat", 0, lat);
        check_val("sat_lat", 64'(lat), 64'd146);
        exp_m = '0;
        exp_m[0][0] = 32'h7FFF_FFFF;
        check_mat("sat_mat", exp_m);

        // -1.0 * 0.5 * 0.5 = -0.25
        clear_inputs();
        eigenvalues[0]        = 32'hFFFF_0000;
        eigenvector_mat[0][0] = 32'h0000_8000;
        num_comp              = 4'd1;
        run("neg", 0, lat);
        check_val("neg_lat", 64'(lat), 64'd74);
        exp_m = '0;
        exp_m[0][0] = 32'hFFFF_C000;
        check_mat("neg_mat", exp_m);

        // 2.0*[.5,.5][.5,.5]^T + (-1.0)*e2 e2^T
        clear_inputs();
        eigenvalues[0]        = 32'h0002_0000;
        eigenvalues[1]        = 32'hFFFF_0000;
        eigenvector_mat[0][0] = 32'h0000_8000;
        eigenvector_mat[0][1] = 32'h0000_8000;
        eigenvector_mat[1][2] = ONE;
        num_comp              = 4'd2;
        run("mixed", 0, lat);
        check_val("mixed_lat", 64'(lat), 64'd146);
        exp_m = '0;
        exp_m[0][0] = 32'h0000_8000;
        exp_m[0][1] = 32'h0000_8000;
        exp_m[1][0] = 32'h0000_8000;
        exp_m[1][1] = 32'h0000_8000;
        exp_m[2][2] = 32'hFFFF_0000;
        check_mat("mixed_mat", exp_m);

        repeat (5) @(posedge clk);
        #1;
        check_mat("hold_mat", exp_m);
        check_val("hold_f", 64'(f), 64'd0);

        // restart and input changes during a run must be ignored
        clear_inputs();
        eigenvalues[0]        = 32'h0003_0000;
        eigenvector_mat[0][0] = ONE;
        num_comp              = 4'd1;
        run("ignore", 10, lat);
        check_val("ignore_lat", 64'(lat), 64'd74);
        exp_m = '0;
        exp_m[0][0] = 32'h0003_0000;
        check_mat("ignore_mat", exp_m);
        @(posedge clk);
        #1;
        check_val("ignore_idle", 64'(busy), 64'd0);

        // num_comp = 0 means all pairs
        eigenvalues     = {N{ONE}};
        eigenvector_mat = ident;
        num_comp        = 4'd0;
        run("k0", 0, lat);
        check_val("k0_lat", 64'(lat), 64'd578);
        check_mat("k0_mat", ident);

        // asynchronous reset in the middle of ACCUM
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_f", 64'(f), 64'd0);
        check_mat("rst_mat", '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        clear_inputs();
        eigenvalues[0]        = 32'h0003_0000;
        eigenvector_mat[0][0] = ONE;
        num_comp              = 4'd1;
        run("post_rst", 0, lat);
        check_val("post_rst_lat", 64'(lat), 64'd74);
        exp_m = '0;
        exp_m[0][0] = 32'h0003_0000;
        check_mat("post_rst_mat", exp_m);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eigen_reconstruct.md
EIGEN_RECONSTRUCT -- requirements
Module: eigen_reconstruct

Interface
REQ-001 SHALL have parameter SIZE_N, default 8: matrix dimension and maximum number of eigenpairs.
REQ-002 SHALL have parameter DATA_W, default 32: signed two's-complement fixed-point width of all data.
REQ-003 SHALL have parameter FRAC_W, default 16: number of fractional bits (1.0 = 0x00010000).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request to rebuild; sampled in IDLE only.
REQ-007 SHALL have port num_comp  input  $clog2(SIZE_N+1)  number K of leading eigenpairs to use.
REQ-008 SHALL have port eigenvalues  input  SIZE_N x DATA_W  eigenvalue k in entry k.
REQ-009 SHALL have port eigenvector_mat  input  SIZE_N x SIZE_N x DATA_W  eigenvector k in row k.
REQ-010 SHALL have port mat_out  output  SIZE_N x SIZE_N x DATA_W  reconstructed matrix sum(k<K) lambda_k * v_k * v_k^T.
REQ-011 SHALL have port busy  output  1  high from LOAD through DONE inclusive.
REQ-012 SHALL have port f  output  1  single-cycle completion pulse; mat_out valid from that cycle.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD -> SCALE -> ACCUM -> (SCALE for next k | DONE) -> IDLE.
REQ-014 IDLE: start=1 SHALL move to LOAD; start=0 SHALL stay in IDLE.
REQ-015 LOAD (1 cycle): SHALL register all eigen inputs and K, clear the accumulator array, set k=0.
REQ-016 K SHALL be clamped: num_comp=0 or num_comp>SIZE_N -> K=SIZE_N.
REQ-017 SCALE (SIZE_N cycles, index i): s[i] = fx_mul(lambda_k, v_k[i]).
REQ-018 ACCUM (SIZE_N*SIZE_N cycles, row-major i then j): acc[i][j] = sat(acc[i][j] + fx_mul(s[i], v_k[j])); one MAC per cycle.
REQ-019 After the last ACCUM element: k<K-1 -> k++ and SCALE; else DONE.
REQ-020 DONE (1 cycle): SHALL copy acc to mat_out, assert f, then return to IDLE.
REQ-021 f SHALL rise exactly 2 + K*(SIZE_N + SIZE_N^2) rising edges after the edge sampling start (74 for N=8,K=1; 578 for N=8,K=8).
REQ-022 fx_mul SHALL form the full 2*DATA_W product, arithmetic-shift right by FRAC_W (truncate toward -inf), then saturate to DATA_W.
REQ-023 Saturation SHALL clamp to 0x7FFF_FFFF / 0x8000_0000 (DATA_W=32); no wrap-around anywhere.
REQ-024 start while busy SHALL be ignored; inputs changing after LOAD SHALL not affect the result.
REQ-025 mat_out SHALL hold its value between DONE cycles.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, busy=0, f=0, mat_out=0, acc=0, s=0, k=0, regardless of state.
REQ-027 After rst deasserts, the first start SHALL produce a full-latency, uncorrupted result.

Structure
REQ-028 Package eig_pkg SHALL hold the fixed-point typedef, DATA_W/FRAC_W defaults, sat() function and FSM state enum.
REQ-029 One sub-module fx_mul SHALL implement REQ-022 combinationally; used for both SCALE and ACCUM.

Verification
REQ-030 Identity: lambda=all 1.0, v_k=e_k, num_comp=8 -> mat_out diagonal 0x00010000, off-diagonal 0, f at edge 578.
REQ-031 Single pair: lambda_0=3.0, v_0=e_0, num_comp=1 -> mat_out[0][0]=0x00030000, rest 0, f at edge 74.
REQ-032 Saturation: lambda_0=lambda_1=0x7FFF0000, v_0=v_1=e_0, num_comp=2 -> mat_out[0][0]=0x7FFFFFFF.
REQ-033 Negative/truncation: lambda_0=-1.0, v_0[0]=0x00008000 (0.5), num_comp=1 -> mat_out[0][0]=0xFFFFC000 (-0.25).
REQ-034 Start pulsed at cycle 10 of a busy run, inputs changed -> ignored, result and f timing unchanged; num_comp=0 -> behaves as K=8.
REQ-035 rst asserted mid-ACCUM -> all outputs 0 same cycle; subsequent start yields the correct result at full latency.
